branch_target_buffer: RTL and testbench

//  Direct-mapped BTB + 2-bit saturating branch history for the IF stage. Looks up PCF each

---
 rtl/branch_target_buffer.sv | 100 ++++++++++
 tb/tb_branch_target_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters,
// EX-stage training, mispredict detection and branch/miss counters.
module branch_target_buffer #(
  parameter int         ENTRY_BITS = 6,
  parameter logic [1:0] ALLOC_CNT  = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        UpdateE,
  input  logic [31:0] PCE,
  input  logic        BrTakenE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 30 - ENTRY_BITS;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic [ENTRY_BITS-1:0] idx_f;
  logic [ENTRY_BITS-1:0] idx_e;
  logic [TAG_W-1:0]      tag_f;
  logic [TAG_W-1:0]      tag_e;
  logic                  hit_f;
  logic                  hit_e;
  logic [1:0]            cnt_e;
  logic [1:0]            cnt_inc;
  logic [1:0]            cnt_dec;
  logic                  unused_pc_lsbs;

  // Byte offset bits never take part in indexing or tagging.
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[ENTRY_BITS+1:2];
  assign tag_f = PCF[31:ENTRY_BITS+2];
  assign idx_e = PCE[ENTRY_BITS+1:2];
  assign tag_e = PCE[31:ENTRY_BITS+2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign PredTakenF  = hit_f && cnt_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;

  assign cnt_e   = cnt_q[idx_e];
  assign cnt_inc = (cnt_e == 2'b11) ? cnt_e : cnt_e + 2'd1;
  assign cnt_dec = (cnt_e == 2'b00) ? cnt_e : cnt_e - 2'd1;

  assign MispredictE = UpdateE &&
    ((BrTakenE != PredTakenE) ||
     (BrTakenE && PredTakenE && (PredTargetE != BrTargetE)));
  assign RecoverPCE  = BrTakenE ? BrTargetE : PCE + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      BranchCnt <= '0;
      MissCnt   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= ALLOC_CNT;
      end
    end else begin
      if (UpdateE) begin
        BranchCnt <= BranchCnt + 32'd1;
        if (hit_e) begin
          cnt_q[idx_e] <= BrTakenE ? cnt_inc : cnt_dec;
        end else if (BrTakenE) begin
          valid_q[idx_e] <= 1'b1;
          cnt_q[idx_e]   <= ALLOC_CNT;
        end
      end
      if (MispredictE) begin
        MissCnt <= MissCnt + 32'd1;
      end
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (UpdateE && BrTakenE) begin
      target_q[idx_e] <= BrTargetE;
      if (!hit_e) begin
        tag_q[idx_e] <= tag_e;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized checks of branch_target_buffer against an
// entry-level behavioural model of the predictor and its counters.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = '0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        UpdateE = 1'b0;
  logic [31:0] PCE = '0;
  logic        BrTakenE = 1'b0;
  logic [31:0] BrTargetE = '0;
  logic        PredTakenE = 1'b0;
  logic [31:0] PredTargetE = '0;
  logic        MispredictE;
  logic [31:0] RecoverPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MissCnt;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateE(UpdateE), .PCE(PCE), .BrTakenE(BrTakenE),
    .BrTargetE(BrTargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .RecoverPCE(RecoverPCE), .BranchCnt(BranchCnt),
    .MissCnt(MissCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  int unsigned m_br;
  int unsigned m_miss;
  logic [31:0] trained [$];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> 8;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_br = 0;
    m_miss = 0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output bit tk,
                            output logic [31:0] tgt);
    int i;
    i = idx_of(pc);
    tk = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step(input bit upd, input logic [31:0] pce, input bit tk,
                      input logic [31:0] tgt, input bit ptk,
                      input logic [31:0] ptgt, input logic [31:0] pcf);
    bit          etk;
    logic [31:0] etgt;
    bit          emis;
    int          i;
    bit          hit;
    UpdateE = upd; PCE = pce; BrTakenE = tk; BrTargetE = tgt;
    PredTakenE = ptk; PredTargetE = ptgt; PCF = pcf;
    #1;
    model_pred(pcf, etk, etgt);
    chk("pred_taken", 32'(PredTakenF), 32'(etk));
    chk("pred_target", PredTargetF, etgt);
    emis = upd && ((tk != ptk) || (tk && ptk && (ptgt != tgt)));
    chk("mispredict", 32'(MispredictE), 32'(emis));
    if (emis) chk("recover_pc", RecoverPCE, tk ? tgt : pce + 32'd4);
    @(posedge clk);
    if (upd) begin
      i = idx_of(pce);
      hit = m_valid[i] && (m_tag[i] == tag_of(pce));
      if (hit && tk) begin
        m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
        m_tgt[i] = tgt;
      end else if (hit) begin
        m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i] = tag_of(pce);
        m_tgt[i] = tgt;
        m_cnt[i] = 2;
      end
      if (tk) trained.push_back(pce);
      m_br++;
      if (emis) m_miss++;
    end
    #1;
    chk("branch_cnt", BranchCnt, m_br);
    chk("miss_cnt", MissCnt, m_miss);
    @(negedge clk);
    UpdateE = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input bit etk,
                      input logic [31:0] etgt);
    UpdateE = 1'b0;
    PCF = pc;
    #1;
    chk("look_taken", 32'(PredTakenF), 32'(etk));
    chk("look_target", PredTargetF, etgt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    UpdateE = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    trained.delete();
  endtask

  initial begin
    bit          ptk;
    logic [31:0] ptgt;
    logic [31:0] pce;
    logic [31:0] pcf;
    int          n;

    do_reset();
    look(32'h100, 1'b0, 32'h104);
    chk("reset_branch_cnt", BranchCnt, 32'h0);
    chk("reset_miss_cnt", MissCnt, 32'h0);

    step(1, 32'h100, 1, 32'h80, 0, 32'h0, 32'h100);
    look(32'h100, 1'b1, 32'h80);
    chk("t2_branch_cnt", BranchCnt, 32'd1);
    chk("t2_miss_cnt", MissCnt, 32'd1);

    repeat (3) step(1, 32'h100, 1, 32'h80, 1, 32'h80, 32'h100);
    step(1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h100);
    look(32'h100, 1'b1, 32'h80);
    step(1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h100);
    look(32'h100, 1'b0, 32'h104);

    step(1, 32'h100, 1, 32'h80, 0, 32'h0, 32'h0);
    step(1, 32'h200, 1, 32'h40, 0, 32'h0, 32'h0);
    look(32'h100, 1'b0, 32'h104);
    look(32'h200, 1'b1, 32'h40);

    do_reset();
    step(1, 32'h100, 1, 32'h80, 0, 32'h0, 32'h100);
    look(32'h100, 1'b1, 32'h80);
    step(1, 32'h100, 1, 32'h80, 1, 32'h84, 32'h100);
    chk("t5_branch_cnt", BranchCnt, 32'd2);
    chk("t5_miss_cnt", MissCnt, 32'd2);

    for (int k = 0; k < 400; k++) begin
      pce = $urandom_range(0, 32'h7FF);
      pcf = ($urandom_range(0, 3) == 0) ? pce : $urandom_range(0, 32'h7FF);
      model_pred(pce, ptk, ptgt);
      if ($urandom_range(0, 3) == 0) ptk = 1'($urandom);
      if ($urandom_range(0, 5) == 0) ptgt = $urandom;
      step(1'($urandom_range(0, 4) != 0), pce, 1'($urandom),
           ($urandom_range(0, 1) == 0) ? 32'h40 : $urandom,
           ptk, ptgt, pcf);
    end

    step(1, 32'h100, 1, 32'h80, 0, 32'h0, 32'h0);
    look(32'h100, 1'b1, 32'h80);
    UpdateE = 1'b1; PCE = 32'h100; BrTakenE = 1'b1;
    BrTargetE = 32'h500; PredTakenE = 1'b0; PredTargetE = 32'h0;
    PCF = 32'h100;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pred_taken", 32'(PredTakenF), 32'h0);
    chk("rst_pred_target", PredTargetF, 32'h104);
    chk("rst_branch_cnt", BranchCnt, 32'h0);
    chk("rst_miss_cnt", MissCnt, 32'h0);
    chk("rst_mispredict", 32'(MispredictE), 32'h1);
    chk("rst_recover_pc", RecoverPCE, 32'h500);
    @(posedge clk);
    @(negedge clk);
    UpdateE = 1'b0;
    rst = 1'b0;
    look(32'h100, 1'b0, 32'h104);
    n = (trained.size() < 30) ? trained.size() : 30;
    for (int k = 0; k < n; k++) look(trained[k], 1'b0, trained[k] + 32'd4);
    chk("post_rst_branch_cnt", BranchCnt, 32'h0);
    chk("post_rst_miss_cnt", MissCnt, 32'h0);
    model_clear();
    step(1, 32'h100, 0, 32'h80, 0, 32'h0, 32'h100);
    look(32'h100, 1'b0, 32'h104);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
